rf_wport_arbiter: RTL and testbench

- Shares the single regfile write port between two requesters:
  - the in-order writeback stage;
  - a long-latency result source (multicycle divider / late uncached load return) that completes out of the pipeline.
- Buffers long-latency results in a small FIFO and grants them idle write slots.
- Forces a slot, by stalling writeback, when a buffered result has waited too long.
- Exposes a pending-write check so issue logic can hold dependent instructions.

---
 rtl/rf_wport_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wport_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Write-port arbiter for the register file: in-order writeback competes with
// buffered long-latency results, with a starvation guard on the buffered side.
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int REG_IDX_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_idx,
  input  logic [31:0]          wb_data,
  output logic                 wb_stall_o,
  input  logic                 lu_valid,
  input  logic [REG_IDX_W-1:0] lu_idx,
  input  logic [31:0]          lu_data,
  output logic                 lu_ready,
  input  logic [REG_IDX_W-1:0] chk_idx,
  output logic                 chk_pending,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [31:0]          reg_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [REG_IDX_W-1:0] idx_mem  [FIFO_DEPTH];
  logic [31:0]          data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 fifo_grant;
  logic                 wb_grant;
  logic                 any_grant;
  logic [REG_IDX_W-1:0] grant_idx;
  logic [31:0]          grant_data;
  logic [FIFO_DEPTH-1:0] hit;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign lu_ready   = ~full;
  assign push       = lu_valid & ~full;

  // The FIFO head wins whenever writeback is idle or has been favoured too long.
  assign fifo_grant = ~empty & (~wb_valid | (starve_cnt == STV_W'(STARVE_LIMIT)));
  assign wb_grant   = wb_valid & ~fifo_grant;
  assign wb_stall_o = wb_valid & fifo_grant;
  assign pop        = fifo_grant;
  assign any_grant  = fifo_grant | wb_grant;

  assign grant_idx  = fifo_grant ? idx_mem[head]  : wb_idx;
  assign grant_data = fifo_grant ? data_mem[head] : wb_data;

  // An entry is live when its distance from head is below the occupancy.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offs;
      assign offs    = PTR_W'(gi) - head;
      assign hit[gi] = (CNT_W'(offs) < count) && (idx_mem[gi] == chk_idx);
    end
  endgenerate

  assign chk_pending = (chk_idx != '0) && (|hit);

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail]  <= lu_idx;
      data_mem[tail] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      reg_we     <= 1'b0;
      reg_idx    <= '0;
      reg_data   <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (pop)
        starve_cnt <= '0;
      else if (~empty && wb_grant && (starve_cnt != STV_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + STV_W'(1);

      // r0 still burns the slot but must never reach the regfile.
      reg_we <= any_grant && (grant_idx != '0);
      if (any_grant) begin
        reg_idx  <= grant_idx;
        reg_data <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: expected regfile writes are queued by the
// stimulus and retired by an independent monitor on the falling edge.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        wb_stall_o;
  logic        lu_valid;
  logic [4:0]  lu_idx;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  chk_idx;
  logic        chk_pending;
  logic        reg_we;
  logic [4:0]  reg_idx;
  logic [31:0] reg_data;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_stall_o(wb_stall_o),
    .lu_valid(lu_valid), .lu_idx(lu_idx), .lu_data(lu_data), .lu_ready(lu_ready),
    .chk_idx(chk_idx), .chk_pending(chk_pending),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] idx, input logic [31:0] data);
    wr_t w;
    w.idx  = idx;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reg_we"},   reg_we,      0);
    chk({tag, "_reg_idx"},  reg_idx,     0);
    chk({tag, "_reg_data"}, reg_data,    0);
    chk({tag, "_lu_ready"}, lu_ready,    1);
    chk({tag, "_pending"},  chk_pending, 0);
    chk({tag, "_stall"},    wb_stall_o,  0);
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && reg_we) begin
      wr_t w;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=idx %0d data %h required=no write", reg_idx, reg_data);
      end else begin
        w = exp_q.pop_front();
        if (reg_idx !== w.idx || reg_data !== w.data) begin
          errors++;
          $display("FAIL write_order actual=idx %0d data %h required=idx %0d data %h",
                   reg_idx, reg_data, w.idx, w.data);
        end else begin
          $display("write idx %0d data %h", reg_idx, reg_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_valid = 0; wb_idx = 0; wb_data = 0;
    lu_valid = 0; lu_idx = 0; lu_data = 0; chk_idx = 0;
    #2;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // writeback only: one-cycle latency, never stalled with an empty FIFO
    tick();
    wb_valid = 1; wb_idx = 3; wb_data = 32'hDEADBEEF;
    expect_wr(3, 32'hDEADBEEF);
    #1 chk("wb_only_stall", wb_stall_o, 0);
    tick();
    wb_valid = 0;
    #1 chk("wb_only_we", reg_we, 1);
    chk("wb_only_idx", reg_idx, 3);

    // long-latency only: pending after accept, written two cycles later
    tick();
    lu_valid = 1; lu_idx = 7; lu_data = 32'h12345678; chk_idx = 7;
    expect_wr(7, 32'h12345678);
    #1 chk("lu_only_ready", lu_ready, 1);
    tick();
    lu_valid = 0;
    #1 chk("lu_only_pending_n1", chk_pending, 1);
    chk("lu_only_no_bypass", reg_we, 0);
    tick();
    #1 chk("lu_only_we_n2", reg_we, 1);
    chk("lu_only_idx_n2", reg_idx, 7);
    chk("lu_only_pending_n2", chk_pending, 0);

    // starvation: four wb grants with a non-empty FIFO, then one forced slot
    tick();
    wb_valid = 1; wb_idx = 10; wb_data = 32'hA0;
    lu_valid = 1; lu_idx = 20; lu_data = 32'hB0;
    expect_wr(10, 32'hA0);
    tick();
    lu_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      wb_idx = 5'(10 + i); wb_data = 32'hA0 + 32'(i);
      expect_wr(wb_idx, wb_data);
      #1 chk($sformatf("starve_nostall_%0d", i), wb_stall_o, 0);
      tick();
    end
    wb_idx = 15; wb_data = 32'hA5;
    expect_wr(20, 32'hB0);
    expect_wr(15, 32'hA5);
    #1 chk("starve_forced_stall", wb_stall_o, 1);
    tick();
    #1 chk("starve_stall_one_cycle", wb_stall_o, 0);
    chk("starve_fifo_slot", reg_idx, 20);
    tick();
    wb_valid = 0;
    #1 chk("starve_held_wb", reg_idx, 15);

    // full FIFO: third result held until a pop, retirement in push order
    tick();
    wb_valid = 1; wb_idx = 1; wb_data = 32'hC0;
    lu_valid = 1; lu_idx = 21; lu_data = 32'hD0;
    expect_wr(1, 32'hC0);
    tick();
    wb_idx = 2; wb_data = 32'hC1;
    lu_idx = 22; lu_data = 32'hD1;
    expect_wr(2, 32'hC1);
    tick();
    wb_idx = 3; wb_data = 32'hC2;
    lu_idx = 23; lu_data = 32'hD2;
    chk_idx = 22;
    expect_wr(3, 32'hC2);
    #1 chk("full_not_ready", lu_ready, 0);
    chk("full_pending_22", chk_pending, 1);
    tick();
    wb_valid = 0; chk_idx = 21;
    expect_wr(21, 32'hD0);
    expect_wr(22, 32'hD1);
    expect_wr(23, 32'hD2);
    #1 chk("full_pop_cycle_ready", lu_ready, 0);
    chk("full_popping_still_pending", chk_pending, 1);
    tick();
    #1 chk("full_ready_after_pop", lu_ready, 1);
    tick();
    lu_valid = 0; chk_idx = 23;
    #1 chk("full_pending_23", chk_pending, 1);
    tick();
    tick();

    // index 0: consumes a slot and pops, never writes
    lu_valid = 1; lu_idx = 0; lu_data = 32'hE0; chk_idx = 0;
    tick();
    lu_valid = 0;
    #1 chk("r0_not_pending", chk_pending, 0);
    tick();
    #1 chk("r0_lu_no_we", reg_we, 0);
    chk("r0_lu_slot_idx", reg_idx, 0);
    chk("r0_lu_slot_data", reg_data, 32'hE0);
    wb_valid = 1; wb_idx = 0; wb_data = 32'hE1;
    tick();
    wb_valid = 0;
    #1 chk("r0_wb_no_we", reg_we, 0);
    chk("r0_wb_data", reg_data, 32'hE1);

    // reset mid-stream with two buffered results; wb to r0 keeps the FIFO full
    tick();
    wb_valid = 1; wb_idx = 0; wb_data = 32'hF0;
    lu_valid = 1; lu_idx = 25; lu_data = 32'hF1;
    tick();
    lu_idx = 26; lu_data = 32'hF2;
    tick();
    lu_valid = 0; chk_idx = 25;
    #1 chk("pre_rst_full", lu_ready, 0);
    chk("pre_rst_pending", chk_pending, 1);
    rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    tick();
    rst = 1'b0; wb_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_no_write_%0d", i), reg_we, 0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
